// File: rtl/positron_layer_serializer_pkg.sv
// Shared helpers for the positron layer serializer.
// Provides the index-width function used to size the word counter.
package positron_layer_serializer_pkg;

  // Ceiling log2, never less than 1 so a single-word window still has a counter bit.
  function automatic int unsigned log2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/positron_layer_serializer_bank.sv
// One storage bank of the serializer's ping-pong buffer.
// Ports:
//   clk, rst_n  - clock and async active-low reset (clears the bank)
//   wr_en_i     - load every word from wr_data_i on this edge
//   wr_data_i   - flattened words, word k at [k*POSIT_WIDTH +: POSIT_WIDTH]
//   rd_idx_i    - word index to read
//   rd_data_o   - word at rd_idx_i (combinational read of stored state)
module positron_layer_serializer_bank #(
  parameter int unsigned POSIT_WIDTH = 4,
  parameter int unsigned NB_POSITRON = 16,
  parameter int unsigned IDX_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en_i,
  input  logic [NB_POSITRON*POSIT_WIDTH-1:0] wr_data_i,
  input  logic [IDX_WIDTH-1:0]              rd_idx_i,
  output logic [POSIT_WIDTH-1:0]            rd_data_o
);

  logic [POSIT_WIDTH-1:0] mem_q [NB_POSITRON];

  // Whole-window write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NB_POSITRON); k++) mem_q[k] <= '0;
    end else if (wr_en_i) begin
      for (int k = 0; k < int'(NB_POSITRON); k++) mem_q[k] <= wr_data_i[k*POSIT_WIDTH +: POSIT_WIDTH];
    end
  end

  // Compare-based read mux keeps the index width independent of the array size
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < int'(NB_POSITRON); k++) begin
      if (rd_idx_i == IDX_WIDTH'(k)) rd_data_o = mem_q[k];
    end
  end

endmodule

// File: rtl/positron_layer_serializer.sv
// Captures one result from each of NB_POSITRON parallel positrons in a single
// transfer into a ping-pong buffer and replays them as one serial posit window
// framed with sow/eow.
// Ports:
//   clk, rst_n - clock and async active-low reset
//   rts_i, eow_i, posit_i - upstream per-positron handshake and flattened results
//   rtr_o      - ready-to-receive broadcast to all upstream positrons
//   rtr_i      - downstream ready-to-receive
//   rts_o, sow_o, eow_o, posit_o - downstream serial window
module positron_layer_serializer
  import positron_layer_serializer_pkg::*;
#(
  parameter int unsigned POSIT_WIDTH = 4,
  parameter int unsigned NB_POSITRON = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NB_POSITRON-1:0]             rts_i,
  input  logic [NB_POSITRON-1:0]             eow_i,
  input  logic [NB_POSITRON*POSIT_WIDTH-1:0] posit_i,
  output logic                               rtr_o,
  input  logic                               rtr_i,
  output logic                               rts_o,
  output logic                               sow_o,
  output logic                               eow_o,
  output logic [POSIT_WIDTH-1:0]             posit_o
);

  localparam int unsigned IDX_WIDTH = log2_min1(NB_POSITRON);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NB_POSITRON - 1);

  logic [1:0]           full_q, full_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 cap_c, xfer_c, last_c;
  logic [POSIT_WIDTH-1:0] rd_data [2];

  // Handshake decode, all from registered state plus inputs
  assign rtr_o  = ~full_q[wr_sel_q];
  assign rts_o  = full_q[rd_sel_q];
  assign cap_c  = rtr_o & (&rts_i) & (&eow_i);
  assign xfer_c = rts_o & rtr_i;
  assign last_c = (idx_q == LAST_IDX);

  assign posit_o = rts_o ? rd_data[rd_sel_q] : '0;
  assign sow_o   = rts_o & (idx_q == '0);
  assign eow_o   = rts_o & last_c;

  // Two storage banks; write side and read side always target different banks
  for (genvar b = 0; b < 2; b++) begin : g_bank
    positron_layer_serializer_bank #(
      .POSIT_WIDTH(POSIT_WIDTH),
      .NB_POSITRON(NB_POSITRON),
      .IDX_WIDTH  (IDX_WIDTH)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en_i  (cap_c && (wr_sel_q == 1'(b))),
      .wr_data_i(posit_i),
      .rd_idx_i (idx_q),
      .rd_data_o(rd_data[b])
    );
  end

  // Next-state: capture and final transfer may hit both banks on one edge
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;
    if (cap_c) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (xfer_c) begin
      if (last_c) begin
        idx_d            = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end else begin
        idx_d = idx_q + IDX_WIDTH'(1);
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_positron_layer_serializer.sv
// Scoreboard bench: a 4-positron serializer and a 1-positron build side by side.
module tb_positron_layer_serializer;

  typedef struct packed {
    logic [3:0] p;
    logic       sow;
    logic       eow;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rts_i, eow_i;
  logic [15:0] posit_i;
  logic        rtr_o, rtr_i, rts_o, sow_o, eow_o;
  logic [3:0]  posit_o;

  logic        rts1_i, eow1_i, rtr1_o, rtr1_i, rts1_o, sow1_o, eow1_o;
  logic [3:0]  posit1_i, posit1_o;

  exp_t q[$];
  exp_t q1[$];
  exp_t e_mon, e_mon1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  positron_layer_serializer #(.POSIT_WIDTH(4), .NB_POSITRON(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .eow_i(eow_i), .posit_i(posit_i),
    .rtr_o(rtr_o), .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o),
    .posit_o(posit_o)
  );

  positron_layer_serializer #(.POSIT_WIDTH(4), .NB_POSITRON(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rts_i(rts1_i), .eow_i(eow1_i), .posit_i(posit1_i),
    .rtr_o(rtr1_o), .rtr_i(rtr1_i), .rts_o(rts1_o), .sow_o(sow1_o), .eow_o(eow1_o),
    .posit_o(posit1_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected words of one 4-word window, index 0 first
  task automatic push_window(input logic [15:0] data);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.p   = data[k*4 +: 4];
      e.sow = (k == 0);
      e.eow = (k == 3);
      q.push_back(e);
    end
  endtask

  // Monitor: every accepted output word is compared against the scoreboard
  always @(negedge clk) begin
    if (rst_n && rts_o && rtr_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", posit_o, $time);
      end else begin
        e_mon = q.pop_front();
        chk("word_posit", 32'(posit_o), 32'(e_mon.p));
        chk("word_sow", 32'(sow_o), 32'(e_mon.sow));
        chk("word_eow", 32'(eow_o), 32'(e_mon.eow));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rts1_o && rtr1_i) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word1: got %0h expected none at %0t", posit1_o, $time);
      end else begin
        e_mon1 = q1.pop_front();
        chk("word1_posit", 32'(posit1_o), 32'(e_mon1.p));
        chk("word1_sow", 32'(sow1_o), 32'(e_mon1.sow));
        chk("word1_eow", 32'(eow1_o), 32'(e_mon1.eow));
      end
    end
  end

  initial begin
    int gaps;
    int c_cyc;
    rst_n = 1'b0; rtr_i = 1'b1; rts_i = '0; eow_i = '0; posit_i = '0;
    rtr1_i = 1'b1; rts1_i = 1'b0; eow1_i = 1'b0; posit1_i = '0;

    // Reset values
    @(negedge clk);
    chk("rst_rts", 32'(rts_o), 0);
    chk("rst_sow", 32'(sow_o), 0);
    chk("rst_eow", 32'(eow_o), 0);
    chk("rst_posit", 32'(posit_o), 0);
    chk("rst_rtr", 32'(rtr_o), 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic window
    @(posedge clk); #1 rts_i = 4'hF; eow_i = 4'hF; posit_i = 16'h4321;
    push_window(16'h4321);
    @(posedge clk); #1 rts_i = '0; eow_i = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("basic_idle_rts", 32'(rts_o), 0);
    chk("basic_drained", 32'(q.size()), 0);

    // Partial valid never captures
    @(posedge clk); #1 rts_i = 4'b0111; eow_i = 4'hF; posit_i = 16'h8765;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("partial_rts", 32'(rts_o), 0);
      chk("partial_rtr", 32'(rtr_o), 1);
    end
    rts_i = 4'hF;
    push_window(16'h8765);
    @(posedge clk); #1 rts_i = '0; eow_i = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("partial_drained", 32'(q.size()), 0);

    // Backpressure after word 0 has gone
    @(posedge clk); #1 rts_i = 4'hF; eow_i = 4'hF; posit_i = 16'h4321;
    push_window(16'h4321);
    @(posedge clk); #1 rts_i = '0; eow_i = '0;
    @(posedge clk); #1 rtr_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_posit_held", 32'(posit_o), 2);
      chk("bp_rts_held", 32'(rts_o), 1);
      chk("bp_sow_low", 32'(sow_o), 0);
      @(posedge clk);
    end
    #1 rtr_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_idle_rts", 32'(rts_o), 0);
    chk("bp_drained", 32'(q.size()), 0);

    // Ping-pong: A, B back to back, C held until the buffer frees
    @(posedge clk); #1 rts_i = 4'hF; eow_i = 4'hF; posit_i = 16'h1111;
    push_window(16'h1111);
    @(posedge clk); #1 posit_i = 16'h2222;
    push_window(16'h2222);
    @(posedge clk); #1 posit_i = 16'h3333;
    gaps = 0;
    c_cyc = -1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (!rts_o) gaps++;
      if (i == 0) chk("pp_rtr_both_full", 32'(rtr_o), 0);
      if (rtr_o && c_cyc < 0) c_cyc = i;
      @(posedge clk);
      if (c_cyc == i) begin
        push_window(16'h3333);
        #1 rts_i = '0; eow_i = '0;
      end
    end
    rts_i = '0; eow_i = '0;
    chk("pp_c_capture_cycle", 32'(c_cyc), 3);
    chk("pp_no_gap", 32'(gaps), 0);
    @(negedge clk);
    chk("pp_idle_rts", 32'(rts_o), 0);
    chk("pp_drained", 32'(q.size()), 0);

    // Reset during word 2
    @(posedge clk); #1 rts_i = 4'hF; eow_i = 4'hF; posit_i = 16'h4321;
    push_window(16'h4321);
    @(posedge clk); #1 rts_i = '0; eow_i = '0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_word2", 32'(posit_o), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rts", 32'(rts_o), 0);
    chk("mid_rst_sow", 32'(sow_o), 0);
    chk("mid_rst_eow", 32'(eow_o), 0);
    chk("mid_rst_posit", 32'(posit_o), 0);
    chk("mid_rst_rtr", 32'(rtr_o), 1);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 rts_i = 4'hF; eow_i = 4'hF; posit_i = 16'hDCBA;
    push_window(16'hDCBA);
    @(posedge clk); #1 rts_i = '0; eow_i = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_rst_drained", 32'(q.size()), 0);

    // Single-positron build
    @(posedge clk); #1 rts1_i = 1'b1; eow1_i = 1'b1; posit1_i = 4'h7;
    q1.push_back('{p: 4'h7, sow: 1'b1, eow: 1'b1});
    @(posedge clk); #1 rts1_i = 1'b0; eow1_i = 1'b0;
    @(negedge clk);
    chk("nb1_rts", 32'(rts1_o), 1);
    @(posedge clk);
    @(negedge clk);
    chk("nb1_idle_rts", 32'(rts1_o), 0);
    chk("nb1_drained", 32'(q1.size()), 0);

    chk("final_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
